// File: rtl/conv_window_fetch_if.sv
// conv_window_fetch_if: control, picture-memory and tile-stream signals of the window fetcher.
interface conv_window_fetch_if #(
    parameter int LANES   = 16,
    parameter int BITS    = 16,
    parameter int ADDR_W  = 15,
    parameter int WADDR_W = 5
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    mem_rd;
    logic [LANES*ADDR_W-1:0] mem_addr;
    logic [LANES*BITS-1:0]   mem_data;
    logic [LANES*BITS-1:0]   map;
    logic                    map_valid;
    logic                    map_ready;
    logic [WADDR_W-1:0]      weight_addr;
    logic                    win_last;

    modport master (
        input  start, mem_data, map_ready,
        output busy, done, mem_rd, mem_addr, map, map_valid, weight_addr, win_last
    );

    modport slave (
        output start, mem_data, map_ready,
        input  busy, done, mem_rd, mem_addr, map, map_valid, weight_addr, win_last
    );
endinterface

// File: rtl/conv_window_fetch.sv
// conv_window_fetch: walks a frame of FILTERxFILTER windows, streaming PAR_HxPAR_W lane tiles.
// Define CONV_FETCH_PAD_EN to honour PAD with out-of-bounds zero masking.
module conv_window_fetch #(
    parameter int BITS     = 16,
    parameter int PAR_H    = 4,
    parameter int PAR_W    = 4,
    parameter int LENGTH   = 100,
    parameter int HEIGHT   = 252,
    parameter int FILTER   = 5,
    parameter int STRIDE_H = 4,
    parameter int STRIDE_W = 4,
    parameter int PAD      = 0,
    parameter int ADDR_W   = 15,
    parameter int WADDR_W  = 5
) (
    input logic clk_in,
    input logic rst_n,
    conv_window_fetch_if.master bus
);
    localparam int LANES = PAR_H * PAR_W;
    localparam int OUT_H = (HEIGHT + 2 * PAD - FILTER) / STRIDE_H + 1;
    localparam int OUT_W = (LENGTH + 2 * PAD - FILTER) / STRIDE_W + 1;
    localparam int CW    = 16;
    localparam int DW    = LANES * BITS;
    localparam int EW    = 1 + WADDR_W + DW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nx;
    logic [CW-1:0] kh, kw, wc, wr;
    logic kh_max, kw_max, wc_max, wr_max, last_rd;
    logic issue, pop, last_hs, rd_q, wl_q, wp, rp;
    logic [1:0] cnt;
    logic [WADDR_W-1:0] wa_q;
    logic [LANES-1:0] oob, oob_q;
    logic [DW-1:0] data_m;
    logic [EW-1:0] fifo [2];

`ifndef CONV_FETCH_PAD_EN
    if (PAD != 0) begin : g_pad_chk
        $error("conv_window_fetch: PAD != 0 requires CONV_FETCH_PAD_EN");
    end
`endif

    assign kh_max  = kh == CW'(FILTER - 1);
    assign kw_max  = kw == CW'(FILTER - 1);
    assign wc_max  = wc == CW'(OUT_W - 1);
    assign wr_max  = wr == CW'(OUT_H - 1);
    assign last_rd = kh_max && kw_max && wc_max && wr_max;
    assign pop     = bus.map_valid && bus.map_ready;
    assign last_hs = pop && cnt == 2'd1 && !rd_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE && bus.start)       ? RUN   :
                   (state == RUN && issue && last_rd) ? DRAIN :
                   (state == DRAIN && last_hs)        ? IDLE  : state;
    end

    // Credit check counts the beat leaving this cycle so a ready consumer sees one beat per cycle.
    always_comb begin
        bus.busy   = state != IDLE;
        issue      = state == RUN && ({1'b0, cnt} + {2'b0, rd_q} - {2'b0, pop}) < 3'd2;
        bus.mem_rd = issue;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            kh <= '0;
            kw <= '0;
            wc <= '0;
            wr <= '0;
        end else if (issue) begin
            kh <= kh_max ? '0 : kh + CW'(1);
            kw <= !kh_max ? kw : kw_max ? '0 : kw + CW'(1);
            wc <= !(kh_max && kw_max) ? wc : wc_max ? '0 : wc + CW'(1);
            wr <= !(kh_max && kw_max && wc_max) ? wr : wr_max ? '0 : wr + CW'(1);
        end
    end

    for (genvar j = 0; j < PAR_H; j++) begin : g_row
        for (genvar k = 0; k < PAR_W; k++) begin : g_col
            localparam int N = j * PAR_W + k;
            logic signed [31:0] row, col;
`ifdef CONV_FETCH_PAD_EN
            assign row    = $signed(32'(wr)) * STRIDE_H + $signed(32'(kh)) + j - PAD;
            assign col    = $signed(32'(wc)) * STRIDE_W + $signed(32'(kw)) + k - PAD;
            assign oob[N] = row < 0 || row >= HEIGHT || col < 0 || col >= LENGTH;
`else
            assign row    = $signed(32'(wr)) * STRIDE_H + $signed(32'(kh)) + j;
            assign col    = $signed(32'(wc)) * STRIDE_W + $signed(32'(kw)) + k;
            assign oob[N] = 1'b0;
`endif
            assign bus.mem_addr[N*ADDR_W +: ADDR_W] =
                (bus.mem_rd && !oob[N]) ? ADDR_W'(row * LENGTH + col) : '0;
            assign data_m[N*BITS +: BITS] = oob_q[N] ? '0 : bus.mem_data[N*BITS +: BITS];
        end
    end

    // Mask and beat tags travel one cycle alongside the read to meet the returning data.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= 1'b0;
            oob_q    <= '0;
            wa_q     <= '0;
            wl_q     <= 1'b0;
            fifo[0]  <= '0;
            fifo[1]  <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            cnt      <= '0;
            bus.done <= 1'b0;
        end else begin
            rd_q  <= issue;
            oob_q <= oob;
            wa_q  <= WADDR_W'(kw * FILTER + kh);
            wl_q  <= kh_max && kw_max;
            if (rd_q) begin
                fifo[wp] <= {wl_q, wa_q, data_m};
                wp       <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt      <= cnt + 2'(rd_q) - 2'(pop);
            bus.done <= state == DRAIN && last_hs;
        end
    end

    assign bus.map         = fifo[rp][DW-1:0];
    assign bus.weight_addr = fifo[rp][DW +: WADDR_W];
    assign bus.win_last    = fifo[rp][EW-1];
    assign bus.map_valid   = cnt != 2'd0;
endmodule
